lsu_io_bank_arbiter: RTL and testbench
======================================

// Module: lsu_io_bank_arbiter
// PURPOSE
// Shares the single read-only memory-mapped input bank (switch/key bank, 32 B) between two requesters:
// port 0 = pipeline LSU (MEM stage), port 1 = debug/monitor read port.
// Round-robin arbitration, valid/ready request handshake, fixed-latency response.
// Drives the bank's address, enable and funct code; registers the bank read data into a response register.
// Rejects illegal loads with an error response and never enables the bank for them.
// PARAMETERS
// ADDR_W  5   byte address width of the bank
// DATA_W  32  read data width
// PORTS
// i_clk           in   1       clock, all state updates on rising edge
// i_rst           in   1       asynchronous reset, active-high
// i_req0_valid    in   1       port 0 request valid
// o_req0_ready    out  1       port 0 request accepted this cycle when valid&ready
// i_req0_addr     in   ADDR_W  port 0 byte address
// i_req0_funct    in   3       port 0 load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
// o_rsp0_valid    out  1       port 0 response valid, single-cycle pulse
// o_rsp0_data     out  DATA_W  port 0 response data (extended by bank)
// o_rsp0_err      out  1       port 0 illegal access flag, qualified by o_rsp0_valid
// i_req1_* / o_req1_ready / o_rsp1_*   same as port 0, for port 1
// o_bank_addr     out  ADDR_W  bank address
// o_bank_en       out  1       bank output enable (bank drives read data only when high)
// o_bank_funct    out  3       bank funct code
// i_bank_rdata    in   DATA_W  bank read data, valid combinationally while o_bank_en=1
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0 (port 0 preferred); all outputs 0: rsp valid/data/err, bank en/addr/funct, readies.
// - FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//   - IDLE: winner chosen combinationally from the valids; o_reqW_ready=1 for the winner only.
//     On accept: latch addr, funct, port id and legality into the command register; go to ACCESS.
//     No valid: stay in IDLE.
//   - ACCESS (1 cycle): if legal, o_bank_en=1 and bank addr/funct driven from the command register;
//     i_bank_rdata is captured at the cycle end. If illegal, o_bank_en=0 and captured data=0. Go to RESP.
//   - RESP (1 cycle): o_rspP_valid=1 for the latched port only, with data/err; the other port's rsp stays 0.
//     Go to IDLE.
// - Latency: accept at cycle N -> bank enabled at N+1 -> rsp_valid at N+2. Max 1 accept per 3 cycles.
//   Ready is never high outside IDLE.
// - Arbitration: only one valid -> it wins. Both valid -> port rr_ptr wins.
//   rr_ptr is set to the other port after every accept, including illegal ones.
// - Bank outputs outside ACCESS: en=0, addr=0, funct=0.
// - Legality: funct in {000,001,010,100,101}.
//   Halfword: addr[0]=0. Word: addr[1:0]=00.
//   Anything else -> err=1, data=0, bank never enabled; same latency as a legal access.
// - rsp_data/rsp_err keep their values after the valid pulse; only valid-qualified values are meaningful.
// - A requester may drop valid without acceptance; no state change results.
// - Reset asserted mid-operation: the in-flight request is dropped, no response is issued,
//   and the block returns to its reset values immediately.
// TESTING
// - Single read: port 0 addr=0 funct=010 with bank rdata=32'hA5A5_1234
//   -> ready0 at N, bank_en=1 addr=0 funct=010 at N+1, rsp0_valid data=32'hA5A5_1234 err=0 at N+2.
// - Contention: both ports valid continuously, addr 0 and 16
//   -> grants alternate 0,1,0,1 every 3 cycles; each rsp goes only to its own port.
// - Illegal: port 1 funct=011, then LW at addr=2, then LH at addr=1
//   -> rsp1_err=1 data=0 at N+2 each time; bank_en never asserts.
// - Boundary: LW at addr=28 and LBU at addr=31 -> err=0, bank_en pulses, data passed through.
// - Reset during ACCESS: assert i_rst
//   -> bank_en drops immediately; no rsp_valid afterwards; next request after reset release goes to port 0 first.
// - Idle and withdrawal: port 0 valid raised and dropped while in RESP
//   -> no accept, no bank_en; FSM returns to IDLE and stays there.

Source files
------------

// File: rtl/lsu_io_bank_arbiter.sv
// Round-robin share of the 32 B read-only input bank between the LSU (port 0) and the debug port (port 1).
// Latency: accept at cycle N, bank enabled at N+1, single-cycle response pulse at N+2.
// Backpressure: ready only in IDLE and only to the winner, so at most one accept every 3 cycles.
module lsu_io_bank_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [2:0]        i_req0_funct,
    output logic              o_rsp0_valid,
    output logic [DATA_W-1:0] o_rsp0_data,
    output logic              o_rsp0_err,

    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [2:0]        i_req1_funct,
    output logic              o_rsp1_valid,
    output logic [DATA_W-1:0] o_rsp1_data,
    output logic              o_rsp1_err,

    output logic [ADDR_W-1:0] o_bank_addr,
    output logic              o_bank_en,
    output logic [2:0]        o_bank_funct,
    input  logic [DATA_W-1:0] i_bank_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    // A load is legal when its funct is a known load and the address is naturally aligned.
    function automatic logic load_legal(input logic [ADDR_W-1:0] addr, input logic [2:0] funct);
        logic ok;
        ok = 1'b0;
        case (funct)
            F_LB, F_LBU: ok = 1'b1;
            F_LH, F_LHU: ok = ~addr[0];
            F_LW:        ok = (addr[1:0] == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t              state_q, state_d;
    logic                rr_q, rr_d;            // port preferred on contention
    logic                cmd_port_q, cmd_port_d;
    logic                cmd_legal_q, cmd_legal_d;
    logic                bank_en_q, bank_en_d;
    logic [ADDR_W-1:0]   bank_addr_q, bank_addr_d;
    logic [2:0]          bank_funct_q, bank_funct_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0]   rsp0_data_q, rsp0_data_d;
    logic [DATA_W-1:0]   rsp1_data_q, rsp1_data_d;
    logic                rsp0_err_q, rsp0_err_d;
    logic                rsp1_err_q, rsp1_err_d;

    logic                grant0, grant1;
    logic                accept;
    logic                sel_port;
    logic [ADDR_W-1:0]   sel_addr;
    logic [2:0]          sel_funct;
    logic                sel_legal;
    logic [DATA_W-1:0]   capture_data;

    // Arbitration: a lone requester wins; on contention the round-robin pointer decides.
    // Ready is forced low under reset so nothing looks accepted while the block is held.
    always_comb begin
        grant0       = i_req0_valid & (~i_req1_valid | ~rr_q);
        grant1       = i_req1_valid & (~i_req0_valid |  rr_q);
        o_req0_ready = (state_q == ST_IDLE) & ~i_rst & grant0;
        o_req1_ready = (state_q == ST_IDLE) & ~i_rst & grant1;
        accept       = o_req0_ready | o_req1_ready;
    end

    // Request mux: pick the winner's command and classify it before it is latched.
    always_comb begin
        sel_port  = grant1;
        sel_addr  = grant1 ? i_req1_addr  : i_req0_addr;
        sel_funct = grant1 ? i_req1_funct : i_req0_funct;
        sel_legal = load_legal(sel_addr, sel_funct);
    end

    // Illegal loads never enable the bank, so their captured data is forced to zero.
    always_comb begin
        capture_data = bank_en_q ? i_bank_rdata : '0;
    end

    // Next-state logic: the command register doubles as the bank drive, so bank outputs
    // are registered and only non-zero during ACCESS for a legal command.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        cmd_port_d   = cmd_port_q;
        cmd_legal_d  = cmd_legal_q;
        bank_en_d    = 1'b0;
        bank_addr_d  = '0;
        bank_funct_d = '0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_err_d   = rsp1_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmd_port_d   = sel_port;
                    cmd_legal_d  = sel_legal;
                    bank_en_d    = sel_legal;
                    bank_addr_d  = sel_legal ? sel_addr  : '0;
                    bank_funct_d = sel_legal ? sel_funct : 3'b000;
                    // Hand preference to the other port, illegal accepts included.
                    rr_d         = ~sel_port;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cmd_port_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_data_d  = capture_data;
                    rsp1_err_d   = ~cmd_legal_q;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_data_d  = capture_data;
                    rsp0_err_d   = ~cmd_legal_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight command without a response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            cmd_port_q   <= 1'b0;
            cmd_legal_q  <= 1'b0;
            bank_en_q    <= 1'b0;
            bank_addr_q  <= '0;
            bank_funct_q <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cmd_port_q   <= cmd_port_d;
            cmd_legal_q  <= cmd_legal_d;
            bank_en_q    <= bank_en_d;
            bank_addr_q  <= bank_addr_d;
            bank_funct_q <= bank_funct_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    assign o_bank_en    = bank_en_q;
    assign o_bank_addr  = bank_addr_q;
    assign o_bank_funct = bank_funct_q;
    assign o_rsp0_valid = rsp0_valid_q;
    assign o_rsp0_data  = rsp0_data_q;
    assign o_rsp0_err   = rsp0_err_q;
    assign o_rsp1_valid = rsp1_valid_q;
    assign o_rsp1_data  = rsp1_data_q;
    assign o_rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_lsu_io_bank_arbiter.sv
// Testbench for lsu_io_bank_arbiter: directed scenarios followed by random two-port traffic.
// A transaction-level model predicts grants, bank activity and responses into a scoreboard queue.
// A separate monitor pops and compares each response when the DUT presents it.
module tb_lsu_io_bank_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              v0, v1;
    logic [ADDR_W-1:0] a0, a1;
    logic [2:0]        f0, f1;
    logic              o_req0_ready, o_req1_ready;
    logic              o_rsp0_valid, o_rsp1_valid;
    logic [DATA_W-1:0] o_rsp0_data, o_rsp1_data;
    logic              o_rsp0_err, o_rsp1_err;
    logic [ADDR_W-1:0] o_bank_addr;
    logic              o_bank_en;
    logic [2:0]        o_bank_funct;
    logic [DATA_W-1:0] i_bank_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] mem [0:31];

    typedef struct {
        int          port;
        logic [4:0]  addr;
        logic [2:0]  funct;
        bit          legal;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_io_bank_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (v0),
        .o_req0_ready (o_req0_ready),
        .i_req0_addr  (a0),
        .i_req0_funct (f0),
        .o_rsp0_valid (o_rsp0_valid),
        .o_rsp0_data  (o_rsp0_data),
        .o_rsp0_err   (o_rsp0_err),
        .i_req1_valid (v1),
        .o_req1_ready (o_req1_ready),
        .i_req1_addr  (a1),
        .i_req1_funct (f1),
        .o_rsp1_valid (o_rsp1_valid),
        .o_rsp1_data  (o_rsp1_data),
        .o_rsp1_err   (o_rsp1_err),
        .o_bank_addr  (o_bank_addr),
        .o_bank_en    (o_bank_en),
        .o_bank_funct (o_bank_funct),
        .i_bank_rdata (i_bank_rdata)
    );

    // Little-endian byte bank with the load's sign/zero extension applied.
    function automatic logic [31:0] bank_read(input logic [4:0] a, input logic [2:0] f);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[a];
        b1 = mem[5'(a + 5'd1)];
        b2 = mem[5'(a + 5'd2)];
        b3 = mem[5'(a + 5'd3)];
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'd0, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit legal_ld(input logic [4:0] a, input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return (a % 2) == 0;
            3'b010:         return (a % 4) == 0;
            default:        return 1'b0;
        endcase
    endfunction

    // The bank only drives real data while enabled; garbage otherwise.
    assign i_bank_rdata = o_bank_en ? bank_read(o_bank_addr, o_bank_funct) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: grants, bank activity, expected responses ----------------
    int   m_busy = 0;   // cycles the shared bank remains occupied after an accept
    int   m_rr   = 0;   // preferred port on contention
    bit   acc_vld = 0;
    exp_t acc;

    always @(negedge clk) begin
        bit   e0, e1;
        exp_t it;
        if (rst) begin
            m_busy  = 0;
            m_rr    = 0;
            acc_vld = 0;
            sb_q.delete();
            chk("rst_ready0", o_req0_ready, 0);
            chk("rst_ready1", o_req1_ready, 0);
            chk("rst_bank_en", o_bank_en, 0);
            chk("rst_bank_addr", o_bank_addr, 0);
            chk("rst_bank_funct", o_bank_funct, 0);
            chk("rst_rsp_valid", {o_rsp0_valid, o_rsp1_valid}, 0);
            chk("rst_rsp_err", {o_rsp0_err, o_rsp1_err}, 0);
            chk("rst_rsp0_data", o_rsp0_data, 0);
            chk("rst_rsp1_data", o_rsp1_data, 0);
        end else begin
            e0 = 0;
            e1 = 0;
            if (m_busy == 0) begin
                if (v0 && (!v1 || m_rr == 0)) e0 = 1;
                else if (v1)                  e1 = 1;
            end
            chk("req0_ready", o_req0_ready, e0);
            chk("req1_ready", o_req1_ready, e1);
            if (acc_vld) begin
                chk("bank_en", o_bank_en, acc.legal);
                chk("bank_addr", o_bank_addr, acc.legal ? acc.addr : 5'd0);
                chk("bank_funct", o_bank_funct, acc.legal ? acc.funct : 3'd0);
            end else begin
                chk("bank_en_idle", o_bank_en, 0);
                chk("bank_addr_idle", o_bank_addr, 0);
                chk("bank_funct_idle", o_bank_funct, 0);
            end
            acc_vld = 0;
            if (e0 || e1) begin
                it.port  = e1 ? 1 : 0;
                it.addr  = e1 ? a1 : a0;
                it.funct = e1 ? f1 : f0;
                it.legal = legal_ld(it.addr, it.funct);
                it.data  = it.legal ? bank_read(it.addr, it.funct) : 32'd0;
                it.due   = cyc + 2;
                sb_q.push_back(it);
                acc     = it;
                acc_vld = 1;
                m_rr    = e0 ? 1 : 0;
                m_busy  = 2;
            end else if (m_busy > 0) begin
                m_busy--;
            end
        end
    end

    // ---------------- monitor: pop and compare whenever a response appears ----------------
    always @(negedge clk) begin
        exp_t it;
        if (!rst) begin
            if (o_rsp0_valid || o_rsp1_valid) begin
                chk("rsp_onehot", {o_rsp0_valid, o_rsp1_valid} == 2'b11, 0);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected @cycle %0d: got valid0=%0b valid1=%0b required none",
                             cyc, o_rsp0_valid, o_rsp1_valid);
                end else begin
                    it = sb_q.pop_front();
                    chk("rsp_port", o_rsp1_valid, it.port);
                    chk("rsp_cycle", cyc, it.due);
                    chk("rsp_data", it.port == 1 ? o_rsp1_data : o_rsp0_data, it.data);
                    chk("rsp_err", it.port == 1 ? o_rsp1_err : o_rsp0_err, !it.legal);
                end
            end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
                it = sb_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing @cycle %0d: got no valid, required port %0d response due %0d",
                         cyc, it.port, it.due);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        v0 = 0;
        v1 = 0;
        repeat (n) step();
    endtask

    // Hold a request until the handshake completes; returns 2 time units into the ACCESS cycle.
    task automatic issue(input int p, input logic [4:0] a, input logic [2:0] f);
        bit got;
        got = 0;
        if (p == 1) begin v1 = 1; a1 = a; f1 = f; end
        else        begin v0 = 1; a0 = a; f0 = f; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (p == 1) ? o_req1_ready : o_req0_ready;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: port %0d got no ready within 20 cycles, required ready", p);
        end
        step();
        if (p == 1) v1 = 0;
        else        v0 = 0;
    endtask

    initial begin
        rst = 1;
        v0 = 0; v1 = 0;
        a0 = 0; a1 = 0;
        f0 = 0; f1 = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'hA5; mem[3] = 8'hA5;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        step();

        // single LW on port 0: data 32'hA5A5_1234
        issue(0, 5'd0, 3'b010);
        idle(4);

        // contention: both ports valid continuously
        a0 = 5'd0;  f0 = 3'b010;
        a1 = 5'd16; f1 = 3'b010;
        v0 = 1; v1 = 1;
        repeat (13) step();
        idle(4);

        // illegal loads on port 1
        issue(1, 5'd4, 3'b011); idle(3);
        issue(1, 5'd2, 3'b010); idle(3);
        issue(1, 5'd1, 3'b001); idle(3);

        // top-of-bank boundaries
        issue(0, 5'd28, 3'b010); idle(3);
        issue(1, 5'd31, 3'b100); idle(3);
        issue(0, 5'd30, 3'b001); idle(3);

        // reset while the bank is enabled; port 0 must win first after release
        issue(0, 5'd4, 3'b010);
        chk("pre_rst_bank_en", o_bank_en, 1);
        rst = 1;
        #1;
        chk("rst_bank_en_async", o_bank_en, 0);
        a0 = 5'd8;  f0 = 3'b010;
        a1 = 5'd12; f1 = 3'b010;
        v0 = 1; v1 = 1;
        repeat (3) step();
        rst = 0;
        repeat (7) step();
        idle(4);

        // withdrawal while in RESP
        issue(0, 5'd8, 3'b000);
        step();
        v0 = 1; a0 = 5'd12; f0 = 3'b010;
        step();
        v0 = 0;
        idle(6);

        // random traffic over a fresh bank image
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 900; i++) begin
            v0 = ($urandom_range(0, 99) < 55);
            v1 = ($urandom_range(0, 99) < 45);
            a0 = 5'($urandom);
            a1 = 5'($urandom);
            f0 = 3'($urandom);
            f1 = 3'($urandom);
            step();
        end
        idle(8);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
